memref_scan_ctrl: RTL and testbench
===================================

// Module: memref_scan_ctrl
// PURPOSE
// - Sequencer that drives the (sel, idx) inputs of the combinational 10x16 memref lookup stage and consumes its 16-bit output.
// - Takes a scan command (select, start index, count) and issues one lookup index per cycle.
// - Streams each looked-up word out over valid/ready and accumulates the words into a running sum.
// - Sits between the host command queue and the lookup stage; the lookup stage itself is instantiated outside this block.
// PARAMETERS
// - DEPTH   10  number of entries in each lookup table; valid idx range is 0..DEPTH-1
// - IDX_W    5  width of the index, start and count fields
// - DATA_W  16  width of a lookup word
// - ACC_W   20  width of the sum accumulator
// PORTS
// - clk        in   1       rising-edge clock
// - rst_n      in   1       asynchronous active-low reset
// - cmd_valid  in   1       command offered
// - cmd_ready  out  1       command accepted when valid&ready
// - cmd_sel    in   1       table select; drives lookup arg1 (1 = first table)
// - cmd_start  in   IDX_W   first index
// - cmd_count  in   IDX_W   number of entries to scan
// - lk_sel     out  1       to lookup stage select input
// - lk_idx     out  IDX_W   to lookup stage index input
// - lk_data    in   DATA_W  combinational result from lookup stage
// - res_valid  out  1       result word valid
// - res_ready  in   1       downstream accepts result
// - res_data   out  DATA_W  result word
// - res_last   out  1       marks final word of a scan
// - sum_valid  out  1       one-cycle pulse; sum holds the final total
// - sum        out  ACC_W   accumulated total of the current/last scan
// - err        out  1       one-cycle pulse on a rejected command
// BEHAVIOUR
// - Reset: state=IDLE.
//   - lk_sel, lk_idx, res_valid, res_data, res_last, sum_valid, sum and err are all 0.
//   - cmd_ready is 1 during and after reset (cmd_ready = state==IDLE).
// - FSM states: IDLE, CHECK, ISSUE, DONE.
// - IDLE: on cmd_valid&cmd_ready, register sel/start/count, clear sum, go to CHECK.
// - CHECK (1 cycle; compare in IDX_W+1 bits):
//   - start+count > DEPTH: err pulses, go to IDLE, no results.
//   - count==0: go to DONE, no results.
//   - Otherwise: lk_sel<=sel, lk_idx<=start, remaining<=count, go to ISSUE.
// - ISSUE: a capture occurs when (!res_valid | res_ready). On a capture:
//   - res_data<=lk_data, res_valid<=1, res_last<=(remaining==1).
//   - sum<=sum+ext(lk_data).
//   - If remaining==1, go to DONE; else lk_idx<=lk_idx+1 and remaining--.
// - Stall: no capture when res_valid & !res_ready.
//   - res_data, res_last, lk_idx and sum all hold.
//   - No data is dropped or duplicated.
// - Word drain: res_valid falls when the word is taken (res_ready) and no new capture occurs.
// - DONE: sum_valid pulses for one cycle, then go to IDLE.
//   - The final word may still be pending; it drains normally.
// - Latency: first res_valid 3 cycles after the command handshake edge.
// - Throughput: 1 word/cycle while res_ready=1.
// - Wrap-around: lk_idx never passes start+count-1, because bounds are checked in CHECK.
// - Arithmetic: sum wraps modulo 2^ACC_W with no saturation.
// - Commands: a new command is accepted only in IDLE.
//   - cmd_ready=0 from the handshake until the return to IDLE.
//   - A command may be accepted in IDLE while the last word is still pending.
// - Reset mid-scan: all state is cleared immediately (async).
//   - The pending word is discarded; no sum_valid is produced.
// CONFIGURATION
// - Macro MEMREF_SCAN_SIGNED_EN selects how lk_data is extended into the ACC_W accumulator.
// - Defined: lk_data is treated as signed and sign-extended.
// - Undefined: lk_data is zero-extended.
// - Nothing else changes.
// TESTING
// Table contents used below: sel=1 holds 11,22,33,44,55,66,77,88,99,111; sel=0 holds 15,25,...,105.
// - Reset: rst_n=0 -> cmd_ready=1, all other outputs 0; release -> stays IDLE.
// - sel=1, start=0, count=10, res_ready=1 -> ten words 0x000B..0x006F on consecutive cycles, res_last on 0x006F, sum_valid with sum=0x0025E.
// - sel=0, start=5, count=5, res_ready toggling 1/0 -> words 0x41,0x4B,0x55,0x5F,0x69 each held while stalled, sum=0x001A9.
// - start=8, count=3 -> err pulse in CHECK, no res_valid, cmd_ready back to 1 two cycles after the handshake.
// - count=0 -> no words; sum_valid with sum=0.
// - Assert rst_n=0 after the third word of a 10-word scan -> outputs zero at once; next command runs cleanly.
// - Lookup stub returns 0xFFFF, count=2 -> sum=0xFFFFE with MEMREF_SCAN_SIGNED_EN, 0x1FFFE without.

Source files
------------

// File: rtl/memref_scan_ctrl_if.sv
// rtl/memref_scan_ctrl_if.sv - command and result stream bundle for memref_scan_ctrl
// master = host/consumer side, slave = scan controller side.
interface memref_scan_ctrl_if #(
  parameter int IDX_W  = 5,
  parameter int DATA_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_sel;
  logic [IDX_W-1:0]  cmd_start;
  logic [IDX_W-1:0]  cmd_count;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_last;

  modport master (
    output cmd_valid, cmd_sel, cmd_start, cmd_count, res_ready,
    input  cmd_ready, res_valid, res_data, res_last
  );

  modport slave (
    input  cmd_valid, cmd_sel, cmd_start, cmd_count, res_ready,
    output cmd_ready, res_valid, res_data, res_last
  );
endinterface

// File: rtl/memref_scan_ctrl.sv
// rtl/memref_scan_ctrl.sv - scan sequencer driving a 10x16 memref lookup and streaming/summing its words
// MEMREF_SCAN_SIGNED_EN: sign-extend lookup words into the accumulator (zero-extend when undefined).
module memref_scan_ctrl #(
  parameter int DEPTH  = 10,
  parameter int IDX_W  = 5,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  memref_scan_ctrl_if.slave bus,
  output logic              lk_sel,
  output logic [IDX_W-1:0]  lk_idx,
  input  logic [DATA_W-1:0] lk_data,
  output logic              sum_valid,
  output logic [ACC_W-1:0]  sum,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, CHECK, ISSUE, DONE} state_t;

  localparam logic [IDX_W:0] DEPTH_L = DEPTH[IDX_W:0];

  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic [IDX_W-1:0]  start_q, start_d;
  logic [IDX_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  remaining_q, remaining_d;
  logic              lk_sel_q, lk_sel_d;
  logic [IDX_W-1:0]  lk_idx_q, lk_idx_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_last_q, res_last_d;
  logic [ACC_W-1:0]  sum_q, sum_d;
  logic              sum_valid_q, sum_valid_d;
  logic              err_q, err_d;
  logic [ACC_W-1:0]  lk_ext;
  logic [IDX_W:0]    scan_end;
  logic              capture;

  always_comb begin
`ifdef MEMREF_SCAN_SIGNED_EN
    lk_ext = {{(ACC_W-DATA_W){lk_data[DATA_W-1]}}, lk_data};
`else
    lk_ext = {{(ACC_W-DATA_W){1'b0}}, lk_data};
`endif
  end

  // Extra bit keeps start+count from wrapping before the bounds compare.
  assign scan_end = {1'b0, start_q} + {1'b0, count_q};
  assign capture  = !res_valid_q || bus.res_ready;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    start_d     = start_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    lk_sel_d    = lk_sel_q;
    lk_idx_d    = lk_idx_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_last_d  = res_last_q;
    sum_d       = sum_q;
    sum_valid_d = 1'b0;
    err_d       = 1'b0;

    if (res_valid_q && bus.res_ready) begin
      res_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          sel_d   = bus.cmd_sel;
          start_d = bus.cmd_start;
          count_d = bus.cmd_count;
          sum_d   = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (scan_end > DEPTH_L) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (count_q == '0) begin
          state_d = DONE;
        end else begin
          lk_sel_d    = sel_q;
          lk_idx_d    = start_q;
          remaining_d = count_q;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (capture) begin
          res_data_d  = lk_data;
          res_valid_d = 1'b1;
          res_last_d  = (remaining_q == IDX_W'(1));
          sum_d       = sum_q + lk_ext;
          if (remaining_q == IDX_W'(1)) begin
            state_d = DONE;
          end else begin
            lk_idx_d    = lk_idx_q + IDX_W'(1);
            remaining_d = remaining_q - IDX_W'(1);
          end
        end
      end
      DONE: begin
        sum_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      start_q     <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      lk_sel_q    <= 1'b0;
      lk_idx_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_last_q  <= 1'b0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      start_q     <= start_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      lk_sel_q    <= lk_sel_d;
      lk_idx_q    <= lk_idx_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_last_q  <= res_last_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_last  = res_last_q;
  assign lk_sel        = lk_sel_q;
  assign lk_idx        = lk_idx_q;
  assign sum           = sum_q;
  assign sum_valid     = sum_valid_q;
  assign err           = err_q;
endmodule

// File: tb/tb_memref_scan_ctrl.sv
// tb/tb_memref_scan_ctrl.sv - scoreboard bench for memref_scan_ctrl with a table lookup stub
// Stimulus pushes expected words/sums; monitor compares on the falling clock edge.
module tb_memref_scan_ctrl;
  logic        clk;
  logic        rst_n;
  logic        lk_sel;
  logic [4:0]  lk_idx;
  logic [15:0] lk_data;
  logic        sum_valid;
  logic [19:0] sum;
  logic        err;

  memref_scan_ctrl_if #(.IDX_W(5), .DATA_W(16)) bus ();

  memref_scan_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .lk_sel    (lk_sel),
    .lk_idx    (lk_idx),
    .lk_data   (lk_data),
    .sum_valid (sum_valid),
    .sum       (sum),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic stub_ff;
  logic rr_toggle;

  function automatic logic [15:0] tbl(input logic s, input logic [4:0] i);
    if (s) return (i == 5'd9) ? 16'd111 : 16'(11 * (int'(i) + 1));
    return 16'(15 + 10 * int'(i));
  endfunction

  always_comb lk_data = stub_ff ? 16'hFFFF : tbl(lk_sel, lk_idx);

  int          n_total;
  int          n_pass;
  int          n_acc;
  int          err_pend;
  logic [16:0] exp_q[$];
  logic [19:0] sum_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: transfers, stall hold, sum pulses, error pulses.
  logic        held_v;
  logic [16:0] held;
  logic [16:0] e;
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v && bus.res_valid) check("stall_hold", {bus.res_last, bus.res_data}, held);
      held_v = 1'b0;
      if (bus.res_valid && bus.res_ready) begin
        n_acc++;
        if (exp_q.size() == 0) check("unexpected_word", {bus.res_last, bus.res_data}, 17'h1FFFF);
        else begin
          e = exp_q.pop_front();
          check("res_word", {bus.res_last, bus.res_data}, e);
        end
      end else if (bus.res_valid) begin
        held_v = 1'b1;
        held   = {bus.res_last, bus.res_data};
      end
      if (sum_valid) begin
        if (sum_q.size() == 0) check("unexpected_sum", {12'd0, sum}, 32'hFFFFFFFF);
        else check("sum", {12'd0, sum}, {12'd0, sum_q.pop_front()});
      end
      if (err) begin
        if (err_pend == 0) check("unexpected_err", 32'd1, 32'd0);
        else err_pend--;
      end
    end
  end

  initial begin
    bus.res_ready = 1'b1;
    @(posedge clk);
    forever begin
      @(posedge clk);
      #1 bus.res_ready = rr_toggle ? ~bus.res_ready : 1'b1;
    end
  end

  task automatic issue(input logic s, input logic [4:0] st, input logic [4:0] cnt);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("cmd_ready_wait", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = s;
    bus.cmd_start = st;
    bus.cmd_count = cnt;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int   k;
    logic done;
    done = 1'b0;
    for (k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && (sum_q.size() == 0) && (err_pend == 0)
             && bus.cmd_ready && !bus.res_valid;
    end
    check("scan_complete", {31'd0, done}, 32'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_cmd_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
    check({tag, "_outs"}, {bus.res_valid, bus.res_last, sum_valid, err, lk_sel, lk_idx, bus.res_data},
          32'd0);
    check({tag, "_sum"}, {12'd0, sum}, 32'd0);
  endtask

  initial begin
    n_total = 0; n_pass = 0; n_acc = 0; err_pend = 0;
    stub_ff = 1'b0; rr_toggle = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_sel = 1'b0; bus.cmd_start = '0; bus.cmd_count = '0;
    held_v = 1'b0; held = '0; e = '0;

    rst_n = 1'b0;
    #1 check_zero_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_zero_outputs("post_reset");

    // Full table 1 at full throughput.
    exp_q.push_back({1'b0, 16'h000B}); exp_q.push_back({1'b0, 16'h0016});
    exp_q.push_back({1'b0, 16'h0021}); exp_q.push_back({1'b0, 16'h002C});
    exp_q.push_back({1'b0, 16'h0037}); exp_q.push_back({1'b0, 16'h0042});
    exp_q.push_back({1'b0, 16'h004D}); exp_q.push_back({1'b0, 16'h0058});
    exp_q.push_back({1'b0, 16'h0063}); exp_q.push_back({1'b1, 16'h006F});
    sum_q.push_back(20'h0025E);
    issue(1'b1, 5'd0, 5'd10);
    wait_done();

    // Table 0 upper half with a stalling consumer; ends exactly at DEPTH.
    rr_toggle = 1'b1;
    exp_q.push_back({1'b0, 16'h0041}); exp_q.push_back({1'b0, 16'h004B});
    exp_q.push_back({1'b0, 16'h0055}); exp_q.push_back({1'b0, 16'h005F});
    exp_q.push_back({1'b1, 16'h0069});
    sum_q.push_back(20'h001A9);
    issue(1'b0, 5'd5, 5'd5);
    wait_done();
    rr_toggle = 1'b0;
    repeat (2) @(negedge clk);

    // Out-of-range scan is rejected.
    err_pend = 1;
    issue(1'b1, 5'd8, 5'd3);
    @(negedge clk);
    check("err_busy", {31'd0, bus.cmd_ready}, 32'd0);
    @(negedge clk);
    check("err_ready_back", {31'd0, bus.cmd_ready}, 32'd1);
    wait_done();

    // Empty scan.
    sum_q.push_back(20'h00000);
    issue(1'b0, 5'd3, 5'd0);
    wait_done();

    // Reset in the middle of a scan.
    n_acc = 0;
    exp_q.push_back({1'b0, 16'h000B}); exp_q.push_back({1'b0, 16'h0016});
    exp_q.push_back({1'b0, 16'h0021}); exp_q.push_back({1'b0, 16'h002C});
    sum_q.push_back(20'h0025E);
    issue(1'b1, 5'd0, 5'd10);
    for (int k = 0; k < 100 && n_acc < 3; k++) @(negedge clk);
    check("three_words_seen", n_acc, 32'd3);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_zero_outputs("mid_reset");
    exp_q.delete();
    sum_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back({1'b0, 16'h000F}); exp_q.push_back({1'b0, 16'h0019});
    exp_q.push_back({1'b1, 16'h0023});
    sum_q.push_back(20'h0004B);
    issue(1'b0, 5'd0, 5'd3);
    wait_done();

    // All-ones words exercise the extension mode.
    stub_ff = 1'b1;
    exp_q.push_back({1'b0, 16'hFFFF}); exp_q.push_back({1'b1, 16'hFFFF});
`ifdef MEMREF_SCAN_SIGNED_EN
    sum_q.push_back(20'hFFFFE);
`else
    sum_q.push_back(20'h1FFFE);
`endif
    issue(1'b1, 5'd0, 5'd2);
    wait_done();
    stub_ff = 1'b0;

    check("err_all_seen", err_pend, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
